fetch_mem_responder: RTL and testbench
======================================

// Module: fetch_mem_responder
// PURPOSE
//  Memory-side responder for instruction fetch. Accepts one PC request at a time,
//  decodes PC[31:28] (0001 = instr cache, 0100 = BIOS, else unmapped), issues a
//  single read to the selected memory, and returns the instruction word to the IF
//  stage. Holds the response under pipeline stall. Sits between the IF stage and
//  the IC/BIOS block RAMs.
// PARAMETERS
//  IC_AW    12  instr-cache word-address width (ic_addr = PC[IC_AW+1:2])
//  BIOS_AW  12  BIOS word-address width (bios_addr = PC[BIOS_AW+1:2])
//  TIMEOUT  16  max cycles waiting for ic_valid before faulting; 0 = wait forever
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  reset        in   1        synchronous, active-high
//  fetch_valid  in   1        IF stage presents a fetch request
//  fetch_pc     in   32       byte PC of request (bits [1:0] ignored)
//  fetch_ready  out  1        responder can accept a request this cycle
//  stall        in   1        IF stage cannot consume response; hold it
//  instr_valid  out  1        instr/instr_fault are valid
//  instr        out  32       fetched instruction word
//  instr_fault  out  1        unmapped region or IC timeout; instr = 0
//  ic_re        out  1        one-cycle read pulse to instr cache
//  ic_addr      out  IC_AW    instr-cache word address
//  ic_dout      in   32       instr-cache read data, valid with ic_valid
//  ic_valid     in   1        instr-cache data ready (variable latency, >=1 cycle)
//  bios_re      out  1        one-cycle read pulse to BIOS
//  bios_addr    out  BIOS_AW  BIOS word address
//  bios_dout    in   32       BIOS read data, valid the cycle after bios_re
// BEHAVIOUR
//  Reset: state IDLE; instr_valid, instr, instr_fault, ic_re, bios_re, ic_addr,
//   bios_addr, timeout counter all 0. fetch_ready = 0 while reset is high.
//  States: IDLE, IC_WAIT, BIOS_WAIT, RESP.
//  fetch_ready = (state==IDLE) && !reset, combinational. Accept = fetch_valid && fetch_ready.
//  IDLE, accept: decode fetch_pc[31:28] in the accept cycle (combinational):
//   0001 -> ic_re=1, ic_addr=fetch_pc[IC_AW+1:2]; next IC_WAIT, counter cleared.
//   0100 -> bios_re=1, bios_addr=fetch_pc[BIOS_AW+1:2]; next BIOS_WAIT.
//   other -> no read pulse; instr<=0, instr_fault<=1; next RESP.
//  ic_re/bios_re are high only in the accept cycle; ic_addr/bios_addr registered and
//   held until next accept.
//  BIOS_WAIT: instr<=bios_dout, instr_fault<=0; next RESP.
//   Latency: accept cycle N -> instr_valid in cycle N+2.
//  IC_WAIT: ic_valid -> instr<=ic_dout, instr_fault<=0, next RESP
//   (instr_valid one cycle after ic_valid).
//   Else counter++; TIMEOUT!=0 && counter==TIMEOUT-1 -> instr<=0, instr_fault<=1, next RESP.
//   ic_valid and timeout in the same cycle: ic_valid wins.
//  RESP: instr_valid=1. stall=0 -> response consumed this cycle, next IDLE.
//   stall=1 -> stay; instr/instr_fault held bit-stable.
//  instr_valid = (state==RESP). Back-to-back rate: one request per 3 cycles (BIOS),
//   per 2 cycles (unmapped).
//  stall is ignored outside RESP. ic_valid is ignored outside IC_WAIT: a stray or
//   late ic_valid is dropped.
//  fetch_valid while fetch_ready=0 is not accepted; requester holds fetch_pc.
//  Reset mid-operation: next cycle is IDLE with all outputs at reset values; the
//   in-flight read is abandoned and its data is never returned.
// TESTING
//  1 BIOS: pc=0x4000_0010 accepted cycle N; bios_re=1 and bios_addr=4 in N;
//    bios_dout=0xDEADBEEF in N+1 -> instr_valid=1, instr=0xDEADBEEF, fault=0 in N+2.
//  2 IC: pc=0x1000_0008 -> ic_re pulse, ic_addr=2; ic_valid with 0x1234_5678
//    3 cycles later -> instr_valid next cycle, instr=0x1234_5678.
//  3 Unmapped pc=0x8000_0000 -> no ic_re/bios_re; next cycle instr_valid=1,
//    instr=0, instr_fault=1.
//  4 stall=1 held 4 cycles in RESP -> instr stable, fetch_ready=0; stall drops ->
//    IDLE next cycle, new request accepted.
//  5 TIMEOUT=8, ic_valid never asserted -> instr_fault=1, instr_valid=1 exactly
//    9 cycles after accept; a later stray ic_valid is ignored.
//  6 reset pulsed during IC_WAIT -> next cycle all outputs 0, state IDLE; ic_valid
//    after reset produces no instr_valid.

Source files
------------

// File: rtl/fetch_mem_responder.sv
// fetch_mem_responder
// Memory-side responder for instruction fetch. Takes one PC at a time from the
// IF stage, routes a single read to the instruction cache or the BIOS ROM based
// on PC[31:28], and returns the instruction word. The response is held while
// the IF stage stalls. Unmapped PCs and instruction-cache timeouts return a
// fault with a zero instruction word.
module fetch_mem_responder #(
  parameter int IC_AW   = 12,
  parameter int BIOS_AW = 12,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic [31:0]        fetch_pc,
  output logic               fetch_ready,
  input  logic               stall,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic               instr_fault,
  output logic               ic_re,
  output logic [IC_AW-1:0]   ic_addr,
  input  logic [31:0]        ic_dout,
  input  logic               ic_valid,
  output logic               bios_re,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout
);

  // The counter only has to reach TIMEOUT-1; keep it at least one bit wide.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    IC_WAIT,
    BIOS_WAIT,
    RESP
  } state_t;

  state_t             state;
  logic [CW-1:0]      wait_cnt;
  logic [IC_AW-1:0]   ic_addr_q;
  logic [BIOS_AW-1:0] bios_addr_q;
  logic               accept;
  logic               sel_ic;
  logic               sel_bios;
  logic               unused_pc;

  // Only some PC bits select a region or a word; fold the rest away.
  assign unused_pc = ^fetch_pc;

  // Decode the request in the accept cycle so the read pulse and address
  // reach the memories without an extra cycle of latency.
  always_comb begin
    fetch_ready = (state == IDLE) && !reset;
    accept      = fetch_valid && fetch_ready;
    sel_ic      = (fetch_pc[31:28] == 4'b0001);
    sel_bios    = (fetch_pc[31:28] == 4'b0100);
    ic_re       = accept && sel_ic;
    bios_re     = accept && sel_bios;
    ic_addr     = ic_re   ? fetch_pc[IC_AW+1:2]   : ic_addr_q;
    bios_addr   = bios_re ? fetch_pc[BIOS_AW+1:2] : bios_addr_q;
    instr_valid = (state == RESP);
  end

  // Request sequencing: issue the read, wait for data or timeout, then hold
  // the response until the IF stage takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ic_addr_q   <= '0;
      bios_addr_q <= '0;
      instr       <= '0;
      instr_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (sel_ic) begin
              ic_addr_q <= fetch_pc[IC_AW+1:2];
              wait_cnt  <= '0;
              state     <= IC_WAIT;
            end else if (sel_bios) begin
              bios_addr_q <= fetch_pc[BIOS_AW+1:2];
              state       <= BIOS_WAIT;
            end else begin
              instr       <= '0;
              instr_fault <= 1'b1;
              state       <= RESP;
            end
          end
        end
        IC_WAIT: begin
          if (ic_valid) begin
            instr       <= ic_dout;
            instr_fault <= 1'b0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
              instr       <= '0;
              instr_fault <= 1'b1;
              state       <= RESP;
            end
          end
        end
        BIOS_WAIT: begin
          instr       <= bios_dout;
          instr_fault <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          if (!stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// tb_fetch_mem_responder
// Directed bench for the fetch responder: BIOS and instruction-cache reads,
// unmapped faults, stall hold, timeout, and reset in the middle of a read.
module tb_fetch_mem_responder;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_fault;
  logic        ic_re;
  logic [11:0] ic_addr;
  logic [31:0] ic_dout;
  logic        ic_valid;
  logic        bios_re;
  logic [11:0] bios_addr;
  logic [31:0] bios_dout;

  int total;
  int bad;

  fetch_mem_responder #(
    .IC_AW(12),
    .BIOS_AW(12),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready),
    .stall(stall),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_fault(instr_fault),
    .ic_re(ic_re),
    .ic_addr(ic_addr),
    .ic_dout(ic_dout),
    .ic_valid(ic_valid),
    .bios_re(bios_re),
    .bios_addr(bios_addr),
    .bios_dout(bios_dout)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every requester/memory input for the current cycle, then let
  // combinational outputs settle before any check.
  task automatic applyStimulus(input logic fv, input logic [31:0] pc,
                               input logic st, input logic icv,
                               input logic [31:0] icd, input logic [31:0] bd);
    fetch_valid = fv;
    fetch_pc    = pc;
    stall       = st;
    ic_valid    = icv;
    ic_dout     = icd;
    bios_dout   = bd;
    #1;
  endtask

  // One comparison: count it, and report tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence with hand-computed expectations.
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_ready",  {31'd0, fetch_ready}, 32'd0);
    checkOutput("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr",  instr, 32'd0);
    checkOutput("rst_fault",  {31'd0, instr_fault}, 32'd0);
    checkOutput("rst_icaddr", {20'd0, ic_addr}, 32'd0);
    checkOutput("rst_baddr",  {20'd0, bios_addr}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("idle_ready", {31'd0, fetch_ready}, 32'd1);

    $display("[TB] BIOS read");
    applyStimulus(1'b1, 32'h4000_0010, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("b_re",     {31'd0, bios_re}, 32'd1);
    checkOutput("b_addr",   {20'd0, bios_addr}, 32'd4);
    checkOutput("b_ic_re",  {31'd0, ic_re}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    checkOutput("b_re_n1",  {31'd0, bios_re}, 32'd0);
    checkOutput("b_addr_n1", {20'd0, bios_addr}, 32'd4);
    checkOutput("b_iv_n1",  {31'd0, instr_valid}, 32'd0);
    checkOutput("b_rdy_n1", {31'd0, fetch_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("b_iv_n2",  {31'd0, instr_valid}, 32'd1);
    checkOutput("b_instr",  instr, 32'hDEAD_BEEF);
    checkOutput("b_fault",  {31'd0, instr_fault}, 32'd0);
    tick();
    checkOutput("b_done_iv",  {31'd0, instr_valid}, 32'd0);
    checkOutput("b_done_rdy", {31'd0, fetch_ready}, 32'd1);

    $display("[TB] IC read");
    applyStimulus(1'b1, 32'h1000_0008, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ic_re",    {31'd0, ic_re}, 32'd1);
    checkOutput("ic_addr",  {20'd0, ic_addr}, 32'd2);
    checkOutput("ic_bre",   {31'd0, bios_re}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ic_re_n1", {31'd0, ic_re}, 32'd0);
    checkOutput("ic_addr_hold", {20'd0, ic_addr}, 32'd2);
    tick();
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
    checkOutput("ic_iv_wait", {31'd0, instr_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ic_iv",    {31'd0, instr_valid}, 32'd1);
    checkOutput("ic_instr", instr, 32'h1234_5678);
    checkOutput("ic_fault", {31'd0, instr_fault}, 32'd0);
    tick();

    $display("[TB] unmapped request with stall hold");
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("um_icre", {31'd0, ic_re}, 32'd0);
    checkOutput("um_bre",  {31'd0, bios_re}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h4000_0020, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("st_iv",    {31'd0, instr_valid}, 32'd1);
      checkOutput("st_instr", instr, 32'd0);
      checkOutput("st_fault", {31'd0, instr_fault}, 32'd1);
      checkOutput("st_rdy",   {31'd0, fetch_ready}, 32'd0);
      checkOutput("st_bre",   {31'd0, bios_re}, 32'd0);
      if (k < 3) tick();
    end
    applyStimulus(1'b1, 32'h4000_0020, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("st_rel_rdy",  {31'd0, fetch_ready}, 32'd1);
    checkOutput("st_rel_iv",   {31'd0, instr_valid}, 32'd0);
    checkOutput("st_rel_bre",  {31'd0, bios_re}, 32'd1);
    checkOutput("st_rel_addr", {20'd0, bios_addr}, 32'd8);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("st_b_iv",    {31'd0, instr_valid}, 32'd1);
    checkOutput("st_b_instr", instr, 32'hCAFE_F00D);
    tick();

    $display("[TB] IC timeout");
    applyStimulus(1'b1, 32'h1000_0000, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("to_icre", {31'd0, ic_re}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("to_iv_wait", {31'd0, instr_valid}, 32'd0);
    end
    tick();
    checkOutput("to_iv",    {31'd0, instr_valid}, 32'd1);
    checkOutput("to_fault", {31'd0, instr_fault}, 32'd1);
    checkOutput("to_instr", instr, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("stray_iv",  {31'd0, instr_valid}, 32'd0);
    checkOutput("stray_rdy", {31'd0, fetch_ready}, 32'd1);

    $display("[TB] ic_valid on the timeout cycle");
    applyStimulus(1'b1, 32'h1000_0040, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("race_addr", {20'd0, ic_addr}, 32'd16);
    for (int k = 1; k <= 7; k++) begin
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h5A5A_A5A5, 32'h0);
    checkOutput("race_iv_wait", {31'd0, instr_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("race_iv",    {31'd0, instr_valid}, 32'd1);
    checkOutput("race_instr", instr, 32'h5A5A_A5A5);
    checkOutput("race_fault", {31'd0, instr_fault}, 32'd0);
    tick();

    $display("[TB] reset during IC wait");
    applyStimulus(1'b1, 32'h1000_0010, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("mr_addr", {20'd0, ic_addr}, 32'd4);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    checkOutput("mr_iv",    {31'd0, instr_valid}, 32'd0);
    checkOutput("mr_instr", instr, 32'd0);
    checkOutput("mr_fault", {31'd0, instr_fault}, 32'd0);
    checkOutput("mr_icaddr", {20'd0, ic_addr}, 32'd0);
    checkOutput("mr_baddr", {20'd0, bios_addr}, 32'd0);
    checkOutput("mr_icre",  {31'd0, ic_re}, 32'd0);
    checkOutput("mr_bre",   {31'd0, bios_re}, 32'd0);
    checkOutput("mr_rdy",   {31'd0, fetch_ready}, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777, 32'h0);
    checkOutput("mr_rdy_after", {31'd0, fetch_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("mr_iv_n1", {31'd0, instr_valid}, 32'd0);
    tick();
    checkOutput("mr_iv_n2", {31'd0, instr_valid}, 32'd0);
    checkOutput("mr_instr_n2", instr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
